// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared encodings for the UART transmit arbiter
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  localparam logic [1:0] LEN_A = 2'd1;
  localparam logic [1:0] LEN_B = 2'd2;

endpackage

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter feeding one- and two-byte frames to a UART transmitter
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [7:0]  data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_a,
  output logic        ack_b,
  input  logic        tx_busy,
  output logic [7:0]  tx_p_data,
  output logic        tx_data_valid,
  output logic        arb_busy,
  output logic        timeout_err
);

  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state, state_nxt;
  grant_t      last_grant, cur_grant, pick;
  logic [15:0] shreg;
  logic [1:0]  bytes_left;
  logic [7:0]  to_cnt;
  logic [7:0]  held_byte;
  logic        take, shift_out, finish;

  always_comb begin
    pick        = (req_b && (!req_a || last_grant == GNT_A)) ? GNT_B : GNT_A;
    state_nxt   = state;
    take        = 1'b0;
    shift_out   = 1'b0;
    finish      = 1'b0;
    ack_a       = 1'b0;
    ack_b       = 1'b0;
    tx_data_valid = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so a request held through reset cannot show an ack.
        if ((req_a || req_b) && !rst) begin
          take      = 1'b1;
          ack_a     = (pick == GNT_A);
          ack_b     = (pick == GNT_B);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_data_valid = 1'b1;
        state_nxt     = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (to_cnt == TO_LAST) begin
          timeout_err = 1'b1;
          finish      = 1'b1;
          state_nxt   = IDLE;
        end else begin
          tx_data_valid = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          shift_out = 1'b1;
          if (bytes_left > 2'd1) begin
            state_nxt = LOAD;
          end else begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb_busy  = (state != IDLE);
  assign tx_p_data = (state == LOAD) ? shreg[7:0] : held_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bytes_left <= '0;
      to_cnt     <= '0;
      held_byte  <= '0;
      cur_grant  <= GNT_A;
      last_grant <= GNT_B;
    end else begin
      if (take) begin
        cur_grant  <= pick;
        shreg      <= (pick == GNT_B) ? data_b : {8'h00, data_a};
        bytes_left <= (pick == GNT_B) ? LEN_B : LEN_A;
      end
      if (state == LOAD) begin
        held_byte <= shreg[7:0];
        to_cnt    <= '0;
      end else if (state == WAIT_HI) begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (shift_out) begin
        shreg      <= {8'h00, shreg[15:8]};
        bytes_left <= bytes_left - 2'd1;
      end
      if (finish) begin
        last_grant <= cur_grant;
      end
      if (timeout_err) begin
        bytes_left <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, tx_busy;
  logic [7:0]  data_a;
  logic [15:0] data_b;
  logic        ack_a, ack_b, tx_data_valid, arb_busy, timeout_err;
  logic [7:0]  tx_p_data;

  always #5 clk = ~clk;

  uart_tx_arb #(.BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .tx_busy(tx_busy), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        ra, rb;
    logic [7:0]  da;
    logic [15:0] db;
    logic        ea, eb;
    int          nb;
    logic [7:0]  b0, b1;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0, n_ack_a = 0, n_ack_b = 0, n_to = 0, run = 0, last_run = 0;
  logic prev_v = 1'b0;
  logic [7:0] got[$];
  logic       got_busy[$];
  logic resp_on = 1'b1, rnd = 1'b0;
  int   rise_dly = 2, busy_len = 10;

  always @(posedge clk) cyc++;

  // Records every strobe start (byte and tx_busy at that moment) and pulse counts.
  always @(negedge clk) begin
    if (tx_data_valid && !prev_v) begin
      got.push_back(tx_p_data);
      got_busy.push_back(tx_busy);
    end
    if (tx_data_valid) run++;
    else if (prev_v) begin last_run = run; run = 0; end
    prev_v = tx_data_valid;
    if (ack_a) n_ack_a++;
    if (ack_b) n_ack_b++;
    if (timeout_err) n_to++;
  end

  // UART transmitter model: busy rises d cycles after a strobe and stays high l cycles.
  initial begin
    int d, l;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_on && tx_data_valid && !tx_busy) begin
        d = rnd ? $urandom_range(1, 3) : rise_dly;
        l = rnd ? $urandom_range(1, 4) : busy_len;
        if (d == 0) #1 tx_busy = 1'b1;
        else begin repeat (d) @(posedge clk); #1 tx_busy = 1'b1; end
        repeat (l) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (arb_busy && k < 300);
    chk(name, arb_busy, 0);
  endtask

  task automatic wait_ack(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(ack_a || ack_b) && k < 300);
    chk(name, ack_a | ack_b, 1);
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int a0, b0, base;
    wait_idle({tag, " pre-idle"});
    base = got.size(); a0 = n_ack_a; b0 = n_ack_b;
    @(posedge clk); #1 req_a = v.ra; data_a = v.da; req_b = v.rb; data_b = v.db;
    wait_ack({tag, " ack seen"});
    chk({tag, " ack_a"}, ack_a, v.ea);
    chk({tag, " ack_b"}, ack_b, v.eb);
    chk({tag, " ack while idle"}, arb_busy, 0);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    wait_idle({tag, " done"});
    chk({tag, " busy low at idle"}, tx_busy, 0);
    chk({tag, " ack_a pulses"}, n_ack_a - a0, v.ea);
    chk({tag, " ack_b pulses"}, n_ack_b - b0, v.eb);
    chk({tag, " byte count"}, got.size() - base, v.nb);
    for (int i = 0; i < 2 && base + i < got.size(); i++) begin
      chk({tag, " byte"}, got[base+i], (i == 0) ? v.b0 : v.b1);
      chk({tag, " strobe after busy low"}, got_busy[base+i], 0);
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int base, k, t0, c_load, nfr, a0, b0;
    logic order[3];
    logic ga, gb, eg, mlast;
    logic [7:0] expq[$];

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 16'h0000, 1'b1, 1'b0, 1, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b1, 2, 8'h34, 8'h12};
    tbl[2] = '{1'b1, 1'b1, 8'h3C, 16'hBEEF, 1'b1, 1'b0, 1, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h11, 16'h2233, 1'b0, 1'b1, 2, 8'h33, 8'h22};
    tbl[4] = '{1'b1, 1'b1, 8'h44, 16'h5566, 1'b1, 1'b0, 1, 8'h44, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 8'h6D, 16'h0000, 1'b1, 1'b0, 1, 8'h6D, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 8'h7E, 16'h8899, 1'b0, 1'b1, 2, 8'h99, 8'h88};

    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 8'hFF; data_b = 16'hFFFF;
    #12;
    chk("reset outputs", {ack_a, ack_b, tx_data_valid, arb_busy, timeout_err, tx_p_data}, 0);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Both requests held from reset: A, then B, then A.
    do_reset();
    base = got.size();
    @(posedge clk); #1 req_a = 1'b1; data_a = 8'hAA; req_b = 1'b1; data_b = 16'hBBCC;
    for (int i = 0; i < 3; i++) begin
      wait_ack("tie ack seen");
      order[i] = ack_b;
      @(posedge clk);
    end
    #1 req_a = 1'b0; req_b = 1'b0;
    wait_idle("tie done");
    chk("tie first grant", order[0], 0);
    chk("tie second grant", order[1], 1);
    chk("tie third grant", order[2], 0);
    chk("tie byte count", got.size() - base, 4);
    if (got.size() - base == 4) begin
      chk("tie byte0", got[base], 8'hAA);
      chk("tie byte1", got[base+1], 8'hCC);
      chk("tie byte2", got[base+2], 8'hBB);
      chk("tie byte3", got[base+3], 8'hAA);
    end

    // Busy already high when WAIT_HI is entered.
    wait_idle("prehigh pre-idle");
    rise_dly = 0; busy_len = 5; base = got.size();
    @(posedge clk); #1 req_a = 1'b1; data_a = 8'hC3;
    wait_ack("prehigh ack");
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk); chk("prehigh strobe", tx_data_valid, 1);
    @(negedge clk); chk("prehigh strobe dropped", tx_data_valid, 0);
    chk("prehigh busy seen", arb_busy, 1);
    @(negedge clk); chk("prehigh waits for low", {arb_busy, tx_busy, tx_data_valid}, 3'b110);
    wait_idle("prehigh done");
    chk("prehigh strobe length", last_run, 1);
    chk("prehigh byte count", got.size() - base, 1);
    chk("prehigh hold byte", tx_p_data, 8'hC3);
    rise_dly = 2; busy_len = 10;

    // Transmitter never answers: abort after BUSY_TIMEOUT cycles.
    resp_on = 1'b0; t0 = n_to;
    @(posedge clk); #1 req_a = 1'b1; data_a = 8'h5A;
    wait_ack("timeout ack");
    chk("timeout ack_a", ack_a, 1);
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk); chk("timeout strobe", tx_data_valid, 1);
    c_load = cyc; k = 0;
    do begin @(negedge clk); k++; end while (!timeout_err && k < 20);
    chk("timeout err seen", timeout_err, 1);
    chk("timeout latency", cyc - c_load, 4);
    chk("timeout valid low", tx_data_valid, 0);
    chk("timeout holds byte", tx_p_data, 8'h5A);
    @(negedge clk);
    chk("timeout back to idle", arb_busy, 0);
    chk("timeout single pulse", n_to - t0, 1);
    resp_on = 1'b1;

    // Reset between the two bytes of a B frame.
    do_reset();
    rise_dly = 1; busy_len = 4; base = got.size();
    @(posedge clk); #1 req_b = 1'b1; data_b = 16'hCAFE;
    wait_ack("midrst ack");
    @(posedge clk); #1 req_b = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!(tx_busy && arb_busy && !tx_data_valid) && k < 50);
    chk("midrst accepted", tx_busy & arb_busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("midrst outputs", {ack_a, ack_b, tx_data_valid, arb_busy, timeout_err, tx_p_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a0 = n_ack_a + n_ack_b; t0 = n_to;
    repeat (8) @(negedge clk);
    chk("midrst no second byte", got.size() - base, 1);
    if (got.size() - base >= 1) chk("midrst first byte", got[base], 8'hFE);
    chk("midrst no ack", n_ack_a + n_ack_b - a0, 0);
    chk("midrst no timeout", n_to - t0, 0);
    v = '{1'b1, 1'b0, 8'h77, 16'h0000, 1'b1, 1'b0, 1, 8'h77, 8'h00};
    run_row(v, "midrst next");
    rise_dly = 2; busy_len = 10;

    // Random requests against the arbitration/byte-stream model.
    do_reset();
    rnd = 1'b1; mlast = 1'b1; t0 = n_to; nfr = 0; base = got.size();
    for (int c = 0; c < 4000 && nfr < 40; c++) begin
      @(negedge clk);
      ga = ack_a; gb = ack_b;
      if (ga || gb) begin
        chk("rnd single ack", ga & gb, 0);
        chk("rnd ack while idle", arb_busy, 0);
        eg = (req_a && req_b) ? !mlast : !req_a;
        chk("rnd grant", gb, eg);
        if (gb) begin expq.push_back(data_b[7:0]); expq.push_back(data_b[15:8]); end
        else expq.push_back(data_a);
        mlast = gb; nfr++;
      end
      @(posedge clk); #1;
      if (ga) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 2) == 0) begin req_a = 1'b1; data_a = 8'($urandom); end
      if (gb) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin req_b = 1'b1; data_b = 16'($urandom); end
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("rnd drain");
    rnd = 1'b0;
    chk("rnd frames", nfr, 40);
    chk("rnd byte count", got.size() - base, expq.size());
    for (int i = 0; i < expq.size() && base + i < got.size(); i++)
      chk($sformatf("rnd byte %0d", i), got[base+i], expq[i]);
    chk("rnd no timeout", n_to - t0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
